// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - op codes and FSM state encoding for the multi-cycle ALU
package alu_mc_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu_mc_comb.sv
// rtl/alu_mc_comb.sv - combinational datapath for the single-cycle ALU ops
// Optional ALU_MC_OVF_EN adds the signed-overflow flag for ADD/SUB.
module alu_mc_comb
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
`ifdef ALU_MC_OVF_EN
    output logic             ovf_o,
`endif
    output logic [WIDTH-1:0] res_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   sh;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign sh   = b_i[SHW-1:0];

    always_comb begin
        res_o = '0;
        case (op_i)
            OP_ADD:  res_o = sum;
            OP_SUB:  res_o = diff;
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_SRL:  res_o = a_i >> sh;
            OP_SRA:  res_o = $signed(a_i) >>> sh;
            OP_SLL:  res_o = a_i << sh;
            OP_XOR:  res_o = a_i ^ b_i;
            default: res_o = '0;
        endcase
    end

`ifdef ALU_MC_OVF_EN
    // Overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
    always_comb begin
        ovf_o = 1'b0;
        if (op_i == OP_ADD) begin
            ovf_o = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
        end else if (op_i == OP_SUB) begin
            ovf_o = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
        end
    end
`endif

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with iterative unsigned mul/div and valid/ready handshakes
// Optional ALU_MC_OVF_EN adds the registered ovf output.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
`ifdef ALU_MC_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int             SHW      = $clog2(WIDTH);
    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
`ifdef ALU_MC_OVF_EN
    logic             ovf_q, ovf_d;
    logic             comb_ovf;
`endif

    logic [WIDTH-1:0] comb_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    alu_mc_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .op_i  (op),
        .a_i   (a),
        .b_i   (b),
`ifdef ALU_MC_OVF_EN
        .ovf_o (comb_ovf),
`endif
        .res_o (comb_res)
    );

    // MUL: {hi,lo} shifts right each step; lo starts as the multiplier and fills with product bits.
    assign mul_sum   = {1'b0, hi_q} + {1'b0, {WIDTH{lo_q[0]}} & opnd_q};

    // DIV: lo starts as the dividend and shifts left, taking quotient bits in at the bottom.
    assign rem_shift = {hi_q, lo_q[WIDTH-1]};
    assign div_diff  = rem_shift - {1'b0, opnd_q};
    assign div_ok    = ~div_diff[WIDTH];
    assign rem_next  = div_ok ? div_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quo_next  = {lo_q[WIDTH-2:0], div_ok};

    always_comb begin
        state_d     = state_q;
        opnd_d      = opnd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
`ifdef ALU_MC_OVF_EN
        ovf_d       = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
`ifdef ALU_MC_OVF_EN
                    ovf_d = comb_ovf;
`endif
                    if (op == OP_MULU || op == OP_DIVU) begin
                        opnd_d  = (op == OP_MULU) ? a : b;
                        lo_d    = (op == OP_MULU) ? b : a;
                        hi_d    = '0;
                        cnt_d   = '0;
                        state_d = (op == OP_MULU) ? S_MUL : S_DIV;
                    end else begin
                        result_d    = comb_res;
                        result_hi_d = '0;
                        state_d     = S_DONE;
                    end
                end
            end
            S_MUL: begin
                hi_d  = mul_sum[WIDTH:1];
                lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    result_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
                    result_hi_d = mul_sum[WIDTH:1];
                    state_d     = S_DONE;
                end
            end
            S_DIV: begin
                hi_d  = rem_next;
                lo_d  = quo_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    result_d    = quo_next;
                    result_hi_d = rem_next;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
`ifdef ALU_MC_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            opnd_q      <= opnd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
`ifdef ALU_MC_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign result    = result_q;
    assign result_hi = result_hi_q;
`ifdef ALU_MC_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - scoreboard bench for alu_mc (ALU_MC_OVF_EN enables the ovf scenario)
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         busy;
`ifdef ALU_MC_OVF_EN
    logic         ovf;
`endif

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
`ifdef ALU_MC_OVF_EN
        .ovf       (ovf),
`endif
        .busy      (busy)
    );

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [2*W-1:0] p;
        logic [W:0]   s;
        logic [4:0]   amt;
        e   = '0;
        amt = y[4:0];
        case (o)
            4'h0: begin e.lo = x + y; s = {x[W-1], x} + {y[W-1], y}; e.ovf = s[W] ^ s[W-1]; end
            4'h1: begin e.lo = x - y; s = {x[W-1], x} - {y[W-1], y}; e.ovf = s[W] ^ s[W-1]; end
            4'h2: e.lo = x & y;
            4'h3: e.lo = x | y;
            4'h4: e.lo = x >> amt;
            4'h5: e.lo = $signed(x) >>> amt;
            4'h6: e.lo = x << amt;
            4'h7: e.lo = x ^ y;
            4'h8: begin p = {{W{1'b0}}, x} * {{W{1'b0}}, y}; e.hi = p[2*W-1:W]; e.lo = p[W-1:0]; end
            4'h9: begin
                if (y == '0) begin e.lo = '1; e.hi = x; end
                else begin e.lo = x / y; e.hi = x % y; end
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int t = 0;
        while (!in_ready) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
                $fatal(1, "in_ready never rose");
            end
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        sb.push_back(model(o, x, y));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (result !== '0 || result_hi !== '0) begin n_fail++; $display("FAIL reset_result: got %h/%h expected 0/0", result_hi, result); end
`ifdef ALU_MC_OVF_EN
        n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [3:0]   ops[10] = '{4'h0, 4'h5, 4'h6, 4'h1, 4'h2, 4'h3, 4'h4, 4'h7, 4'hA, 4'hF};
        logic [W-1:0] as[10]  = '{32'hFFFFFFFF, 32'h80000000, 32'h1, 32'h3, 32'hF0F0A5A5, 32'h0F000001,
                                  32'h80000000, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFF};
        logic [W-1:0] bs[10]  = '{32'h1, 32'h24, 32'd31, 32'h5, 32'hFF00FF00, 32'h00F00010,
                                  32'hFFFFFFE3, 32'hFFFF0000, 32'h9, 32'h1};
        int   n;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            send(ops[i], as[i], bs[i]);
            wait_out(n);
            e = sb.pop_front();
            n_checks++; if (n != 0) begin n_fail++; $display("FAIL single_latency op=%h: got %0d extra cycles expected 0", ops[i], n); end
            n_checks++; if (result !== e.lo) begin n_fail++; $display("FAIL single_result op=%h: got %h expected %h", ops[i], result, e.lo); end
            n_checks++; if (result_hi !== e.hi) begin n_fail++; $display("FAIL single_hi op=%h: got %h expected %h", ops[i], result_hi, e.hi); end
            release_out();
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL single_idle op=%h: in_ready got %b expected 1", ops[i], in_ready); end
        end
    endtask

    task automatic test_mul();
        logic [W-1:0] as[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0001_0003};
        logic [W-1:0] bs[3] = '{32'h2, 32'hFFFFFFFF, 32'h0};
        int   n;
        int   bc;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            send(4'h8, as[i], bs[i]);
            n = 0; bc = 0;
            while (!out_valid && n < 200) begin
                if (busy && !in_ready) bc++;
                @(negedge clk);
                n++;
            end
            e = sb.pop_front();
            n_checks++; if (n != W) begin n_fail++; $display("FAIL mul_latency %0d: got %0d expected %0d", i, n, W); end
            n_checks++; if (bc != W) begin n_fail++; $display("FAIL mul_busy %0d: got %0d busy cycles expected %0d", i, bc, W); end
            n_checks++; if (result !== e.lo || result_hi !== e.hi) begin n_fail++; $display("FAIL mul_result %0d: got %h_%h expected %h_%h", i, result_hi, result, e.hi, e.lo); end
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_done_busy %0d: got %b expected 0", i, busy); end
            release_out();
        end
    endtask

    task automatic test_div();
        logic [W-1:0] as[4] = '{32'd100, 32'd5, 32'hFFFFFFFF, 32'h0};
        logic [W-1:0] bs[4] = '{32'd7, 32'd0, 32'h10, 32'd3};
        int   n;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            send(4'h9, as[i], bs[i]);
            wait_out(n);
            e = sb.pop_front();
            n_checks++; if (n != W) begin n_fail++; $display("FAIL div_latency %0d: got %0d expected %0d", i, n, W); end
            n_checks++; if (result !== e.lo) begin n_fail++; $display("FAIL div_quotient %0d: got %h expected %h", i, result, e.lo); end
            n_checks++; if (result_hi !== e.hi) begin n_fail++; $display("FAIL div_remainder %0d: got %h expected %h", i, result_hi, e.hi); end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        int   n;
        exp_t e;
        send(4'h0, 32'd10, 32'd20);
        wait_out(n);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            op = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom;
            @(negedge clk);
            n_checks++; if (result !== e.lo || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold %0d: got %h valid=%b expected %h valid=1", i, result, out_valid, e.lo); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready %0d: got %b expected 0", i, in_ready); end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0 || result !== e.lo) begin n_fail++; $display("FAIL bp_no_accept: out_valid=%b result=%h expected 0/%h", out_valid, result, e.lo); end
    endtask

    task automatic test_reset_mid();
        int   n;
        int   seen;
        exp_t e;
        send(4'h8, $urandom, $urandom);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags: out_valid=%b busy=%b expected 0/0", out_valid, busy); end
        n_checks++; if (result !== '0 || result_hi !== '0) begin n_fail++; $display("FAIL rst_mid_result: got %h/%h expected 0/0", result_hi, result); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_in_ready: got %b expected 1", in_ready); end
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rst_mid_discard: got %0d out_valid cycles expected 0", seen); end
        send(4'h0, 32'd3, 32'd4);
        wait_out(n);
        e = sb.pop_front();
        n_checks++; if (n != 0 || result !== 32'd7 || result !== e.lo) begin n_fail++; $display("FAIL rst_mid_add: got %0d/%h expected 0/%h", n, result, 32'd7); end
        release_out();
    endtask

    task automatic test_back_to_back();
        int         n;
        exp_t       e;
        logic [3:0] o;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            o = (i < 2) ? 4'(8 + i) : 4'($urandom_range(0, 11));
            send(o, $urandom, $urandom);
            wait_out(n);
            e = sb.pop_front();
            n_checks++; if (!out_valid) begin n_fail++; $display("FAIL b2b_timeout %0d: out_valid got 0 expected 1", i); end
            n_checks++; if (result !== e.lo || result_hi !== e.hi) begin n_fail++; $display("FAIL b2b_result %0d op=%h: got %h_%h expected %h_%h", i, o, result_hi, result, e.hi, e.lo); end
            @(negedge clk);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready %0d: got %b expected 1", i, in_ready); end
        end
        out_ready = 1'b0;
    endtask

`ifdef ALU_MC_OVF_EN
    task automatic test_ovf();
        logic [3:0]   ops[4] = '{4'h0, 4'h1, 4'h0, 4'h1};
        logic [W-1:0] as[4]  = '{32'h7FFFFFFF, 32'h80000000, 32'h1, 32'h5};
        logic [W-1:0] bs[4]  = '{32'h1, 32'h1, 32'h1, 32'h3};
        logic         req[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int   n;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            send(ops[i], as[i], bs[i]);
            wait_out(n);
            e = sb.pop_front();
            n_checks++; if (ovf !== req[i] || ovf !== e.ovf) begin n_fail++; $display("FAIL ovf %0d: got %b expected %b", i, ovf, req[i]); end
            release_out();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_mul();
        test_div();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef ALU_MC_OVF_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

endmodule
